mem_port_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single unified memory port between the instruction-fetch unit (IF) and the load/store unit (LSU). It accepts one request at a time and issues it to memory as a one-cycle registered command. It then waits for the memory response, bounded by a timeout, and returns the response to the owning requester. Its `sel_o` output drives the `mux2` select that steers shared datapath signals toward the current owner.

---
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Round-robin owner of the unified memory port, shared by instruction fetch (IF) and load/store (LSU).
// One transaction is in flight at a time: grant in IDLE, a registered command in ISSUE, a bounded wait in WAIT.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_err_o,

    input  logic          ls_req_i,
    input  logic          ls_we_i,
    input  logic [AW-1:0] ls_addr_i,
    input  logic [DW-1:0] ls_wdata_i,
    output logic          ls_gnt_o,
    output logic          ls_rvalid_o,
    output logic [DW-1:0] ls_rdata_o,
    output logic          ls_err_o,

    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_rvalid_i,
    input  logic [DW-1:0] mem_rdata_i,

    output logic          sel_o,
    output logic          busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q,     state_d;
    logic          owner_q,     owner_d;
    logic          last_q,      last_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          if_err_q,    if_err_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic          ls_rvalid_q, ls_rvalid_d;
    logic          ls_err_q,    ls_err_d;
    logic [DW-1:0] ls_rdata_q,  ls_rdata_d;

    logic          grant_if;
    logic          grant_ls;
    logic          resp_fire;
    logic          resp_err;
    logic [DW-1:0] resp_data;

    // Grants are suppressed while reset is held so every output sits at its reset value.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state_q == S_IDLE && !rst_i) begin
            if (if_req_i && ls_req_i) begin
                grant_if = (last_q == OWNER_LS);
                grant_ls = (last_q == OWNER_IF);
            end else begin
                grant_if = if_req_i;
                grant_ls = ls_req_i;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        resp_fire   = 1'b0;
        resp_err    = 1'b0;
        resp_data   = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_if || grant_ls) begin
                    owner_d     = grant_ls ? OWNER_LS : OWNER_IF;
                    last_d      = grant_ls ? OWNER_LS : OWNER_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = grant_ls & ls_we_i;
                    mem_addr_d  = grant_ls ? ls_addr_i : if_addr_i;
                    mem_wdata_d = grant_ls ? ls_wdata_i : '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response arriving on the last counted cycle still wins over the abort.
                if (mem_rvalid_i) begin
                    resp_fire = 1'b1;
                    resp_data = mem_rdata_i;
                    state_d   = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Only the owner's response lanes ever carry anything; the other side stays at zero.
    always_comb begin
        if_rvalid_d = resp_fire & (owner_q == OWNER_IF);
        if_err_d    = resp_err  & (owner_q == OWNER_IF);
        if_rdata_d  = (owner_q == OWNER_IF) ? resp_data : '0;
        ls_rvalid_d = resp_fire & (owner_q == OWNER_LS);
        ls_err_d    = resp_err  & (owner_q == OWNER_LS);
        ls_rdata_d  = (owner_q == OWNER_LS) ? resp_data : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_q     <= OWNER_IF;
            last_q      <= OWNER_LS;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_err_q    <= ls_err_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign if_gnt_o    = grant_if;
    assign ls_gnt_o    = grant_ls;
    assign if_rvalid_o = if_rvalid_q;
    assign if_err_o    = if_err_q;
    assign if_rdata_o  = if_rdata_q;
    assign ls_rvalid_o = ls_rvalid_q;
    assign ls_err_o    = ls_err_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign sel_o       = owner_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-timing model (grant cycle, command cycle, response cycle per transaction).
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          if_req_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic          if_gnt_o, if_rvalid_o, if_err_o;
    logic [DW-1:0] if_rdata_o;
    logic          ls_req_i = 1'b0;
    logic          ls_we_i = 1'b0;
    logic [AW-1:0] ls_addr_i = '0;
    logic [DW-1:0] ls_wdata_i = '0;
    logic          ls_gnt_o, ls_rvalid_o, ls_err_o;
    logic [DW-1:0] ls_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          sel_o, busy_o;

    int cmp_cnt = 0;
    int bad_cnt = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
        .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .sel_o(sel_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish before it");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i = 1'b0; ls_req_i = 1'b0; ls_we_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic test_reset();
        #1;
        rst_i = 1'b1;
        if_req_i = 1'b1; ls_req_i = 1'b1; ls_we_i = 1'b1;
        if_addr_i = 32'hFFFF_FFF0; ls_addr_i = '1; ls_wdata_i = '1;
        mem_rvalid_i = 1'b1; mem_rdata_i = '1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            cmp_cnt++;
            if ({if_gnt_o, ls_gnt_o} !== 2'b00) begin
                bad_cnt++; $display("FAIL reset_gnt: got %b required 00", {if_gnt_o, ls_gnt_o});
            end
            cmp_cnt++;
            if ({if_rvalid_o, if_err_o, ls_rvalid_o, ls_err_o} !== 4'b0000) begin
                bad_cnt++; $display("FAIL reset_resp: got %b required 0000", {if_rvalid_o, if_err_o, ls_rvalid_o, ls_err_o});
            end
            cmp_cnt++;
            if ({mem_req_o, mem_we_o, sel_o, busy_o} !== 4'b0000) begin
                bad_cnt++; $display("FAIL reset_ctrl: got %b required 0000", {mem_req_o, mem_we_o, sel_o, busy_o});
            end
            cmp_cnt++;
            if ({mem_addr_o, mem_wdata_o, if_rdata_o, ls_rdata_o} !== 128'd0) begin
                bad_cnt++; $display("FAIL reset_data: got %h %h %h %h required all zero", mem_addr_o, mem_wdata_o, if_rdata_o, ls_rdata_o);
            end
        end
        idle_inputs();
        tick();
        rst_i = 1'b0;
        #1;
        cmp_cnt++;
        if (busy_o !== 1'b0) begin
            bad_cnt++; $display("FAIL reset_release_busy: got %b required 0", busy_o);
        end
        $display("reset: done");
    endtask

    task automatic test_contention();
        logic          own;
        logic          pown;
        logic [DW-1:0] rd;
        for (int t = 0; t < 5; t++) begin
            own  = 1'(t % 2);
            pown = 1'((t + 1) % 2);
            tick();
            mem_rvalid_i = 1'b0;
            if (t == 0) begin
                if_req_i = 1'b1; if_addr_i = 32'h0000_0A00;
                ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h0000_0B00;
            end
            if (t == 4) begin
                if_req_i = 1'b0; ls_req_i = 1'b0;
            end
            #1;
            if (t > 0) begin
                rd = 32'h1000_0000 + DW'(t - 1);
                cmp_cnt++;
                if ({if_rvalid_o, ls_rvalid_o} !== (pown ? 2'b01 : 2'b10)) begin
                    bad_cnt++; $display("FAIL contention_rvalid t=%0d: got %b required %b", t, {if_rvalid_o, ls_rvalid_o}, pown ? 2'b01 : 2'b10);
                end
                cmp_cnt++;
                if ((pown ? ls_rdata_o : if_rdata_o) !== rd || (pown ? if_rdata_o : ls_rdata_o) !== 32'd0) begin
                    bad_cnt++; $display("FAIL contention_rdata t=%0d: got if=%h ls=%h required owner=%h other=0", t, if_rdata_o, ls_rdata_o, rd);
                end
                cmp_cnt++;
                if (sel_o !== pown) begin
                    bad_cnt++; $display("FAIL contention_sel_hold t=%0d: got %b required %b", t, sel_o, pown);
                end
                $display("contention: response %0d to %s data %h", t - 1, pown ? "LSU" : "IF", rd);
            end
            if (t < 4) begin
                cmp_cnt++;
                if ({if_gnt_o, ls_gnt_o} !== (own ? 2'b01 : 2'b10)) begin
                    bad_cnt++; $display("FAIL contention_gnt t=%0d: got %b required %b", t, {if_gnt_o, ls_gnt_o}, own ? 2'b01 : 2'b10);
                end
                tick(); #1;
                cmp_cnt++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== (own ? 32'h0000_0B00 : 32'h0000_0A00) || sel_o !== own) begin
                    bad_cnt++; $display("FAIL contention_cmd t=%0d: got req=%b addr=%h sel=%b required 1 %h %b",
                                        t, mem_req_o, mem_addr_o, sel_o, own ? 32'h0000_0B00 : 32'h0000_0A00, own);
                end
                tick();
                mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1000_0000 + DW'(t);
                #1;
            end
        end
    endtask

    task automatic test_single_if_read();
        tick(); if_req_i = 1'b1; if_addr_i = 32'h0000_0100; #1;
        cmp_cnt++;
        if ({if_gnt_o, ls_gnt_o} !== 2'b10) begin
            bad_cnt++; $display("FAIL if_read_gnt: got %b required 10", {if_gnt_o, ls_gnt_o});
        end
        tick(); if_req_i = 1'b0; #1;
        cmp_cnt++;
        if ({mem_req_o, mem_we_o, sel_o} !== 3'b100 || mem_addr_o !== 32'h0000_0100) begin
            bad_cnt++; $display("FAIL if_read_cmd: got req/we/sel=%b addr=%h required 100 00000100", {mem_req_o, mem_we_o, sel_o}, mem_addr_o);
        end
        tick(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; #1;
        cmp_cnt++;
        if ({mem_req_o, if_rvalid_o, busy_o} !== 3'b001) begin
            bad_cnt++; $display("FAIL if_read_wait: got req/rvalid/busy=%b required 001", {mem_req_o, if_rvalid_o, busy_o});
        end
        tick(); mem_rvalid_i = 1'b0; mem_rdata_i = '0; #1;
        cmp_cnt++;
        if ({if_rvalid_o, if_err_o, ls_rvalid_o, busy_o, sel_o} !== 5'b10000 || if_rdata_o !== 32'hDEAD_BEEF || ls_rdata_o !== 32'd0) begin
            bad_cnt++; $display("FAIL if_read_resp: got flags=%b if_rdata=%h ls_rdata=%h required 10000 deadbeef 0",
                                {if_rvalid_o, if_err_o, ls_rvalid_o, busy_o, sel_o}, if_rdata_o, ls_rdata_o);
        end
        tick(); #1;
        cmp_cnt++;
        if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'd0) begin
            bad_cnt++; $display("FAIL if_read_pulse: got rvalid=%b rdata=%h required 0 0", if_rvalid_o, if_rdata_o);
        end
        $display("if_read: addr 00000100 data deadbeef");
    endtask

    task automatic test_ls_write();
        tick(); ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h0000_0040; ls_wdata_i = 32'h0000_55AA; #1;
        cmp_cnt++;
        if ({if_gnt_o, ls_gnt_o} !== 2'b01) begin
            bad_cnt++; $display("FAIL ls_write_gnt: got %b required 01", {if_gnt_o, ls_gnt_o});
        end
        tick(); ls_req_i = 1'b0; ls_we_i = 1'b0; #1;
        cmp_cnt++;
        if ({mem_req_o, mem_we_o, sel_o} !== 3'b111 || mem_addr_o !== 32'h0000_0040 || mem_wdata_o !== 32'h0000_55AA) begin
            bad_cnt++; $display("FAIL ls_write_cmd: got req/we/sel=%b addr=%h wdata=%h required 111 00000040 000055aa",
                                {mem_req_o, mem_we_o, sel_o}, mem_addr_o, mem_wdata_o);
        end
        tick(); mem_rvalid_i = 1'b1; mem_rdata_i = '0; #1;
        tick(); mem_rvalid_i = 1'b0; #1;
        cmp_cnt++;
        if ({ls_rvalid_o, ls_err_o, if_rvalid_o} !== 3'b100) begin
            bad_cnt++; $display("FAIL ls_write_ack: got rvalid/err/if_rvalid=%b required 100", {ls_rvalid_o, ls_err_o, if_rvalid_o});
        end
        $display("ls_write: addr 00000040 wdata 000055aa acknowledged");
    endtask

    task automatic test_timeout();
        tick(); ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h0000_0080; #1;
        cmp_cnt++;
        if (ls_gnt_o !== 1'b1) begin
            bad_cnt++; $display("FAIL timeout_gnt: got %b required 1", ls_gnt_o);
        end
        tick(); ls_req_i = 1'b0; mem_rdata_i = 32'hCAFE_F00D; #1;
        cmp_cnt++;
        if (mem_req_o !== 1'b1) begin
            bad_cnt++; $display("FAIL timeout_cmd: got %b required 1", mem_req_o);
        end
        for (int k = 0; k < TO; k++) begin
            tick(); #1;
            cmp_cnt++;
            if ({ls_rvalid_o, busy_o} !== 2'b01) begin
                bad_cnt++; $display("FAIL timeout_wait k=%0d: got rvalid/busy=%b required 01", k, {ls_rvalid_o, busy_o});
            end
        end
        tick(); #1;
        cmp_cnt++;
        if ({ls_rvalid_o, ls_err_o, busy_o, if_rvalid_o} !== 4'b1100 || ls_rdata_o !== 32'd0) begin
            bad_cnt++; $display("FAIL timeout_abort: got rvalid/err/busy/if_rvalid=%b rdata=%h required 1100 0",
                                {ls_rvalid_o, ls_err_o, busy_o, if_rvalid_o}, ls_rdata_o);
        end
        tick(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678; #1;
        tick(); mem_rvalid_i = 1'b0; #1;
        cmp_cnt++;
        if ({ls_rvalid_o, if_rvalid_o, busy_o, mem_req_o} !== 4'b0000 || ls_rdata_o !== 32'd0) begin
            bad_cnt++; $display("FAIL timeout_late_resp: got rvalids/busy/req=%b rdata=%h required 0000 0",
                                {ls_rvalid_o, if_rvalid_o, busy_o, mem_req_o}, ls_rdata_o);
        end
        $display("timeout: addr 00000080 aborted with err");
    endtask

    task automatic test_reset_mid_wait();
        tick(); ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h0000_003C; ls_wdata_i = 32'h0000_A5A5; #1;
        tick(); ls_req_i = 1'b0; #1;
        tick(); #1;
        cmp_cnt++;
        if ({busy_o, sel_o, mem_we_o} !== 3'b111) begin
            bad_cnt++; $display("FAIL midwait_pre: got busy/sel/we=%b required 111", {busy_o, sel_o, mem_we_o});
        end
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h0000_0200; ls_req_i = 1'b1; ls_we_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0077;
        rst_i = 1'b1;
        #1;
        cmp_cnt++;
        if ({if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, mem_req_o, mem_we_o, sel_o, busy_o} !== 8'd0 ||
            {mem_addr_o, mem_wdata_o} !== 64'd0) begin
            bad_cnt++; $display("FAIL midwait_reset: got flags=%b addr=%h wdata=%h required all zero",
                                {if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, mem_req_o, mem_we_o, sel_o, busy_o}, mem_addr_o, mem_wdata_o);
        end
        for (int k = 0; k < 2; k++) begin
            tick(); #1;
            cmp_cnt++;
            if ({if_rvalid_o, ls_rvalid_o, busy_o} !== 3'b000) begin
                bad_cnt++; $display("FAIL midwait_no_resp k=%0d: got %b required 000", k, {if_rvalid_o, ls_rvalid_o, busy_o});
            end
        end
        tick(); rst_i = 1'b0; mem_rvalid_i = 1'b0; #1;
        cmp_cnt++;
        if ({if_gnt_o, ls_gnt_o} !== 2'b10) begin
            bad_cnt++; $display("FAIL midwait_first_grant: got %b required 10", {if_gnt_o, ls_gnt_o});
        end
        tick(); if_req_i = 1'b0; #1;
        cmp_cnt++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0200) begin
            bad_cnt++; $display("FAIL midwait_cmd: got req=%b addr=%h required 1 00000200", mem_req_o, mem_addr_o);
        end
        tick(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_600D; #1;
        tick(); mem_rvalid_i = 1'b0; ls_req_i = 1'b0; #1;
        cmp_cnt++;
        if ({if_rvalid_o, ls_rvalid_o} !== 2'b10 || if_rdata_o !== 32'h0000_600D) begin
            bad_cnt++; $display("FAIL midwait_after_resp: got rvalids=%b rdata=%h required 10 0000600d", {if_rvalid_o, ls_rvalid_o}, if_rdata_o);
        end
        $display("reset_mid_wait: transaction dropped, IF granted first after release");
    endtask

    task automatic test_back_to_back();
        logic exp_g, exp_rv;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) begin if_req_i = 1'b1; if_addr_i = 32'h0000_0300; end
            if (i == 15) if_req_i = 1'b0;
            mem_rvalid_i = (i % 3 == 2);
            mem_rdata_i  = 32'hB000_0000 + DW'(i);
            #1;
            exp_g  = (i % 3 == 0) && (i < 15);
            exp_rv = (i % 3 == 0) && (i > 0);
            cmp_cnt++;
            if ({if_gnt_o, if_rvalid_o, mem_req_o} !== {exp_g, exp_rv, 1'(i % 3 == 1)}) begin
                bad_cnt++; $display("FAIL b2b i=%0d: got gnt/rvalid/req=%b required %b", i,
                                    {if_gnt_o, if_rvalid_o, mem_req_o}, {exp_g, exp_rv, 1'(i % 3 == 1)});
            end
            if (exp_rv) begin
                cmp_cnt++;
                if (if_rdata_o !== 32'hB000_0000 + DW'(i - 1)) begin
                    bad_cnt++; $display("FAIL b2b_data i=%0d: got %h required %h", i, if_rdata_o, 32'hB000_0000 + DW'(i - 1));
                end
                $display("back_to_back: response at offset %0d data %h", i, if_rdata_o);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] sched [int];
        int            gnt_cyc = -100;
        int            resp_cyc = -100;
        int            lat;
        logic          own = 1'b0, exp_sel = 1'b0, last = 1'b1, exp_err = 1'b0;
        logic          exp_we = 1'b0, win_if, win_ls, rv_if, rv_ls;
        logic [AW-1:0] exp_addr = '0;
        logic [DW-1:0] exp_wdata = '0, exp_data = '0, exp_rd;
        idle_inputs();
        tick(); rst_i = 1'b1;
        tick(); rst_i = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            tick();
            if (c == gnt_cyc + 1) begin
                if (own) ls_req_i = 1'b0; else if_req_i = 1'b0;
            end
            if (!if_req_i && $urandom_range(0, 2) == 0) begin
                if_req_i = 1'b1; if_addr_i = $urandom;
            end
            if (!ls_req_i && $urandom_range(0, 2) == 0) begin
                ls_req_i = 1'b1; ls_we_i = 1'($urandom_range(0, 1));
                ls_addr_i = $urandom; ls_wdata_i = $urandom;
            end
            if (sched.exists(c)) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = sched[c]; sched.delete(c);
            end else if ((c < gnt_cyc + 2 || c >= resp_cyc) && $urandom_range(0, 7) == 0) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
            end else begin
                mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
            end
            #1;
            if (c == gnt_cyc + 1) exp_sel = own;
            rv_if  = (c == resp_cyc) && !own;
            rv_ls  = (c == resp_cyc) && own;
            exp_rd = exp_err ? '0 : exp_data;
            cmp_cnt++;
            if ({if_rvalid_o, if_err_o, ls_rvalid_o, ls_err_o} !== {rv_if, rv_if & exp_err, rv_ls, rv_ls & exp_err}) begin
                bad_cnt++; $display("FAIL rand_resp c=%0d: got %b required %b", c,
                                    {if_rvalid_o, if_err_o, ls_rvalid_o, ls_err_o}, {rv_if, rv_if & exp_err, rv_ls, rv_ls & exp_err});
            end
            cmp_cnt++;
            if (if_rdata_o !== (rv_if ? exp_rd : '0) || ls_rdata_o !== (rv_ls ? exp_rd : '0)) begin
                bad_cnt++; $display("FAIL rand_rdata c=%0d: got if=%h ls=%h required if=%h ls=%h", c,
                                    if_rdata_o, ls_rdata_o, rv_if ? exp_rd : '0, rv_ls ? exp_rd : '0);
            end
            if (c == resp_cyc)
                $display("random: txn owner=%s err=%b data=%h", own ? "LSU" : "IF", exp_err, exp_rd);
            cmp_cnt++;
            if (mem_req_o !== 1'(c == gnt_cyc + 1)) begin
                bad_cnt++; $display("FAIL rand_mem_req c=%0d: got %b required %b", c, mem_req_o, 1'(c == gnt_cyc + 1));
            end
            if (c == gnt_cyc + 1) begin
                cmp_cnt++;
                if (mem_we_o !== exp_we || mem_addr_o !== exp_addr || (exp_we && mem_wdata_o !== exp_wdata)) begin
                    bad_cnt++; $display("FAIL rand_payload c=%0d: got we=%b addr=%h wdata=%h required %b %h %h", c,
                                        mem_we_o, mem_addr_o, mem_wdata_o, exp_we, exp_addr, exp_wdata);
                end
            end
            cmp_cnt++;
            if ({busy_o, sel_o} !== {1'(c > gnt_cyc && c < resp_cyc), exp_sel}) begin
                bad_cnt++; $display("FAIL rand_busy_sel c=%0d: got %b required %b", c,
                                    {busy_o, sel_o}, {1'(c > gnt_cyc && c < resp_cyc), exp_sel});
            end
            win_if = 1'b0; win_ls = 1'b0;
            if (c >= resp_cyc) begin
                if (if_req_i && ls_req_i) begin
                    win_ls = !last; win_if = last;
                end else begin
                    win_if = if_req_i; win_ls = ls_req_i;
                end
            end
            cmp_cnt++;
            if ({if_gnt_o, ls_gnt_o} !== {win_if, win_ls}) begin
                bad_cnt++; $display("FAIL rand_gnt c=%0d: got %b required %b", c, {if_gnt_o, ls_gnt_o}, {win_if, win_ls});
            end
            if (win_if || win_ls) begin
                own       = win_ls;
                last      = win_ls;
                gnt_cyc   = c;
                lat       = int'($urandom_range(1, TO + 2));
                exp_err   = (lat > TO);
                exp_data  = $urandom;
                sched[c + 1 + lat] = exp_data;
                resp_cyc  = c + 2 + (exp_err ? TO : lat);
                exp_we    = win_ls & ls_we_i;
                exp_addr  = win_ls ? ls_addr_i : if_addr_i;
                exp_wdata = ls_wdata_i;
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_if_read();
        test_ls_write();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

endmodule
